// File: rtl/apb_master_if.sv
// apb_master_if: bundles the command port, the response port and the APB4
// requester/completer signals of apb_master.
//   master modport : the apb_master side (consumes commands, drives APB).
//   slave modport  : the environment side (issues commands, acts as completer).
// Parameters: AW address width, DW data width, SW strobe width (DW/8).
interface apb_master_if #(
   parameter int AW = 32,
   parameter int DW = 32,
   parameter int SW = DW / 8
);
   // command port
   logic          cmd_valid;
   logic          cmd_ready;
   logic          cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic [SW-1:0] cmd_strb;
   logic [2:0]    cmd_prot;
   logic          cmd_nse;
   // response port
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_slverr;
   logic          rsp_timeout;
   // APB4 requester outputs
   logic [AW-1:0] PADDR;
   logic [2:0]    PPROT;
   logic          PNSE;
   logic          PSEL;
   logic          PENABLE;
   logic          PWRITE;
   logic [DW-1:0] PWDATA;
   logic [SW-1:0] PSTRB;
   // APB4 completer inputs
   logic [DW-1:0] PRDATA;
   logic          PREADY;
   logic          PSLVERR;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot, cmd_nse,
      output cmd_ready,
      output rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
      input  rsp_ready,
      output PADDR, PPROT, PNSE, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot, cmd_nse,
      input  cmd_ready,
      input  rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
      output rsp_ready,
      input  PADDR, PPROT, PNSE, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
      output PRDATA, PREADY, PSLVERR
   );
endinterface

// File: rtl/apb_master.sv
// apb_master: single-outstanding APB4 requester. A command accepted on the
// valid/ready command port becomes one SETUP/ACCESS transfer; the result is
// held on the valid/ready response port until consumed. A programmable
// wait-state limit aborts transfers whose completer never raises PREADY.
// Ports:
//   PCLK    - clock, rising edge
//   PRESETn - asynchronous active-low reset
//   bus     - apb_master_if.master: cmd_*, rsp_*, APB4 signals
// Parameters: AW, DW (multiple of 8), SW = DW/8, TIMEOUT (0 = no timeout).
module apb_master #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int SW      = DW / 8,
   parameter int TIMEOUT = 16
) (
   input  logic          PCLK,
   input  logic          PRESETn,
   apb_master_if.master  bus
);

   // A zero TIMEOUT still needs a legal 1-bit counter.
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] CNT_MAX = '1;
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

   state_e        state_q,   state_d;
   logic [AW-1:0] paddr_q,   paddr_d;
   logic [2:0]    pprot_q,   pprot_d;
   logic          pnse_q,    pnse_d;
   logic          pwrite_q,  pwrite_d;
   logic [DW-1:0] pwdata_q,  pwdata_d;
   logic [SW-1:0] pstrb_q,   pstrb_d;
   logic [DW-1:0] rdata_q,   rdata_d;
   logic          slverr_q,  slverr_d;
   logic          timeout_q, timeout_d;
   logic [CW-1:0] cnt_q,     cnt_d;

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q   <= IDLE;
         paddr_q   <= '0;
         pprot_q   <= '0;
         pnse_q    <= 1'b0;
         pwrite_q  <= 1'b0;
         pwdata_q  <= '0;
         pstrb_q   <= '0;
         rdata_q   <= '0;
         slverr_q  <= 1'b0;
         timeout_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         paddr_q   <= paddr_d;
         pprot_q   <= pprot_d;
         pnse_q    <= pnse_d;
         pwrite_q  <= pwrite_d;
         pwdata_q  <= pwdata_d;
         pstrb_q   <= pstrb_d;
         rdata_q   <= rdata_d;
         slverr_q  <= slverr_d;
         timeout_q <= timeout_d;
         cnt_q     <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      paddr_d   = paddr_q;
      pprot_d   = pprot_q;
      pnse_d    = pnse_q;
      pwrite_d  = pwrite_q;
      pwdata_d  = pwdata_q;
      pstrb_d   = pstrb_q;
      rdata_d   = rdata_q;
      slverr_d  = slverr_q;
      timeout_d = timeout_q;
      cnt_d     = cnt_q;
      case (state_q)
         IDLE: begin
            if (bus.cmd_valid) begin
               paddr_d  = bus.cmd_addr;
               pprot_d  = bus.cmd_prot;
               pnse_d   = bus.cmd_nse;
               pwrite_d = bus.cmd_write;
               // Reads drive zero data/strobes onto the bus.
               pwdata_d = bus.cmd_write ? bus.cmd_wdata : '0;
               pstrb_d  = bus.cmd_write ? bus.cmd_strb  : '0;
               state_d  = SETUP;
            end
         end
         SETUP: begin
            cnt_d   = '0;
            state_d = ACCESS;
         end
         ACCESS: begin
            if (bus.PREADY) begin
               // PREADY wins over a timeout landing on the same edge.
               rdata_d   = pwrite_q ? '0 : bus.PRDATA;
               slverr_d  = bus.PSLVERR;
               timeout_d = 1'b0;
               state_d   = RESP;
            end else begin
               if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
               // Abort on the TIMEOUT-th consecutive low edge.
               if (TIMEOUT != 0 && (int'(cnt_q) + 1 == TIMEOUT)) begin
                  rdata_d   = '0;
                  slverr_d  = 1'b1;
                  timeout_d = 1'b1;
                  state_d   = RESP;
               end
            end
         end
         RESP: begin
            if (bus.rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Control outputs decode straight from state so reset drops PSEL/PENABLE at once.
   assign bus.cmd_ready   = (state_q == IDLE);
   assign bus.PSEL        = (state_q == SETUP) || (state_q == ACCESS);
   assign bus.PENABLE     = (state_q == ACCESS);
   assign bus.rsp_valid   = (state_q == RESP);
   assign bus.PADDR       = paddr_q;
   assign bus.PPROT       = pprot_q;
   assign bus.PNSE        = pnse_q;
   assign bus.PWRITE      = pwrite_q;
   assign bus.PWDATA      = pwdata_q;
   assign bus.PSTRB       = pstrb_q;
   assign bus.rsp_rdata   = rdata_q;
   assign bus.rsp_slverr  = slverr_q;
   assign bus.rsp_timeout = timeout_q;

endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: directed bench for apb_master. The bench plays both the
// command issuer and the APB completer; outputs are sampled 1 time unit
// after the rising edge, inputs are driven at the same point.
module tb_apb_master;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = 4;
   localparam int TO = 16;

   logic PCLK;
   logic PRESETn;
   int   n_cmp;
   int   n_err;

   apb_master_if #(.AW(AW), .DW(DW), .SW(SW)) bus ();

   apb_master #(.AW(AW), .DW(DW), .SW(SW), .TIMEOUT(TO)) dut (
      .PCLK    (PCLK),
      .PRESETn (PRESETn),
      .bus     (bus)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge PCLK);
      #1;
   endtask

   task automatic cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] st, input logic [2:0] prot, input logic nse);
      bus.cmd_valid = 1'b1;
      bus.cmd_write = wr;
      bus.cmd_addr  = addr;
      bus.cmd_wdata = wd;
      bus.cmd_strb  = st;
      bus.cmd_prot  = prot;
      bus.cmd_nse   = nse;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      PRESETn       = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_wdata = '0;
      bus.cmd_strb  = '0;
      bus.cmd_prot  = '0;
      bus.cmd_nse   = 1'b0;
      bus.rsp_ready = 1'b1;
      bus.PRDATA    = '0;
      bus.PREADY    = 1'b1;
      bus.PSLVERR   = 1'b0;
      #2;
      // reset state
      chk("rst_cmd_ready", bus.cmd_ready, 1);
      chk("rst_psel",      bus.PSEL, 0);
      chk("rst_penable",   bus.PENABLE, 0);
      chk("rst_paddr",     bus.PADDR, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_rdata",     bus.rsp_rdata, 0);
      cyc();
      PRESETn = 1'b1;
      cyc();

      // 1: zero-wait write
      bus.PRDATA = 32'h1234_5678;
      cmd(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 3'b010, 1'b1);
      chk("w_cmd_ready_idle", bus.cmd_ready, 1);
      cyc(); bus.cmd_valid = 1'b0;
      chk("w_setup_psel",    bus.PSEL, 1);
      chk("w_setup_pen",     bus.PENABLE, 0);
      chk("w_setup_rdy",     bus.cmd_ready, 0);
      chk("w_paddr",         bus.PADDR, 32'h10);
      chk("w_pwdata",        bus.PWDATA, 32'hDEAD_BEEF);
      chk("w_pstrb",         bus.PSTRB, 4'hF);
      chk("w_pwrite",        bus.PWRITE, 1);
      chk("w_pprot",         bus.PPROT, 3'b010);
      chk("w_pnse",          bus.PNSE, 1);
      cyc();
      chk("w_access_psel",   bus.PSEL, 1);
      chk("w_access_pen",    bus.PENABLE, 1);
      cyc();
      chk("w_resp_valid",    bus.rsp_valid, 1);
      chk("w_resp_psel",     bus.PSEL, 0);
      chk("w_resp_pen",      bus.PENABLE, 0);
      chk("w_resp_rdata",    bus.rsp_rdata, 0);
      chk("w_resp_slverr",   bus.rsp_slverr, 0);
      chk("w_resp_to",       bus.rsp_timeout, 0);
      chk("w_hold_paddr",    bus.PADDR, 32'h10);
      cyc();
      chk("w_idle_valid",    bus.rsp_valid, 0);
      chk("w_idle_ready",    bus.cmd_ready, 1);

      // 2: read with two wait states
      bus.PREADY = 1'b0;
      bus.PRDATA = 32'h0;
      cmd(1'b0, 32'h10, 32'hFFFF_FFFF, 4'hF, 3'b000, 1'b0);
      cyc(); bus.cmd_valid = 1'b0;
      chk("r_pwdata_zero",   bus.PWDATA, 0);
      chk("r_pstrb_zero",    bus.PSTRB, 0);
      chk("r_pwrite",        bus.PWRITE, 0);
      cyc();
      chk("r_access1",       bus.PENABLE, 1);
      cyc();
      chk("r_access2",       bus.PENABLE, 1);
      cyc();
      chk("r_access3",       bus.PENABLE, 1);
      chk("r_access3_valid", bus.rsp_valid, 0);
      bus.PREADY = 1'b1;
      bus.PRDATA = 32'hDEAD_BEEF;
      cyc();
      chk("r_resp_valid",    bus.rsp_valid, 1);
      chk("r_resp_rdata",    bus.rsp_rdata, 32'hDEAD_BEEF);
      chk("r_resp_slverr",   bus.rsp_slverr, 0);
      cyc();
      chk("r_idle",          bus.cmd_ready, 1);

      // 3: write with PSLVERR
      bus.PSLVERR = 1'b1;
      cmd(1'b1, 32'h4000, 32'h0000_00A5, 4'h1, 3'b001, 1'b0);
      cyc(); bus.cmd_valid = 1'b0;
      chk("e_paddr",         bus.PADDR, 32'h4000);
      chk("e_pstrb",         bus.PSTRB, 4'h1);
      cyc(); cyc();
      chk("e_resp_valid",    bus.rsp_valid, 1);
      chk("e_resp_slverr",   bus.rsp_slverr, 1);
      chk("e_resp_to",       bus.rsp_timeout, 0);
      bus.PSLVERR = 1'b0;
      cyc();

      // 4a: timeout with PREADY held low
      bus.PREADY = 1'b0;
      bus.PRDATA = 32'hAAAA_5555;
      cmd(1'b0, 32'h20, 32'h0, 4'h0, 3'b000, 1'b0);
      cyc(); bus.cmd_valid = 1'b0;
      cyc();
      for (int k = 1; k < TO; k++) begin
         chk($sformatf("t_access%0d", k), bus.PENABLE, 1);
         cyc();
      end
      chk("t_access16",      bus.PENABLE, 1);
      chk("t_access16_valid", bus.rsp_valid, 0);
      cyc();
      chk("t_resp_valid",    bus.rsp_valid, 1);
      chk("t_resp_psel",     bus.PSEL, 0);
      chk("t_resp_slverr",   bus.rsp_slverr, 1);
      chk("t_resp_to",       bus.rsp_timeout, 1);
      chk("t_resp_rdata",    bus.rsp_rdata, 0);
      cyc();

      // 4b: PREADY rises on the 16th ACCESS edge -> normal completion
      cmd(1'b0, 32'h24, 32'h0, 4'h0, 3'b000, 1'b0);
      cyc(); bus.cmd_valid = 1'b0;
      cyc();
      for (int k = 1; k < TO; k++) cyc();
      chk("tb_access16",     bus.PENABLE, 1);
      bus.PREADY = 1'b1;
      bus.PRDATA = 32'hCAFE_F00D;
      cyc();
      chk("tb_resp_valid",   bus.rsp_valid, 1);
      chk("tb_resp_to",      bus.rsp_timeout, 0);
      chk("tb_resp_slverr",  bus.rsp_slverr, 0);
      chk("tb_resp_rdata",   bus.rsp_rdata, 32'hCAFE_F00D);
      cyc();

      // 5: response backpressure with a pending command
      bus.rsp_ready = 1'b0;
      cmd(1'b1, 32'h100, 32'h1111_2222, 4'h3, 3'b000, 1'b0);
      cyc();
      bus.cmd_addr = 32'h200;
      cyc(); cyc();
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("bp_valid%0d", k), bus.rsp_valid, 1);
         chk($sformatf("bp_ready%0d", k), bus.cmd_ready, 0);
         chk($sformatf("bp_psel%0d", k),  bus.PSEL, 0);
         cyc();
      end
      chk("bp_paddr_first",  bus.PADDR, 32'h100);
      bus.rsp_ready = 1'b1;
      cyc();
      chk("bp_idle_ready",   bus.cmd_ready, 1);
      chk("bp_idle_valid",   bus.rsp_valid, 0);
      cyc(); bus.cmd_valid = 1'b0;
      chk("bp_second_psel",  bus.PSEL, 1);
      chk("bp_second_paddr", bus.PADDR, 32'h200);
      cyc(); cyc();
      chk("bp_second_resp",  bus.rsp_valid, 1);
      cyc();

      // 6: reset in the middle of ACCESS
      bus.PREADY = 1'b0;
      cmd(1'b1, 32'h300, 32'h5A5A_5A5A, 4'hF, 3'b111, 1'b1);
      cyc(); bus.cmd_valid = 1'b0;
      cyc();
      chk("rm_access",       bus.PENABLE, 1);
      #2 PRESETn = 1'b0;
      #1;
      chk("rm_psel",         bus.PSEL, 0);
      chk("rm_penable",      bus.PENABLE, 0);
      chk("rm_paddr",        bus.PADDR, 0);
      chk("rm_pwdata",       bus.PWDATA, 0);
      chk("rm_pwrite",       bus.PWRITE, 0);
      chk("rm_cmd_ready",    bus.cmd_ready, 1);
      chk("rm_rsp_valid",    bus.rsp_valid, 0);
      cyc();
      PRESETn = 1'b1;
      bus.PREADY = 1'b1;
      cyc();
      chk("rm_after_valid",  bus.rsp_valid, 0);
      chk("rm_after_psel",   bus.PSEL, 0);
      cyc();
      chk("rm_after_valid2", bus.rsp_valid, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/apb_master.md
# apb_master

APB requester that turns a simple valid/ready command port into APB4 transfers (PSEL/PENABLE/PREADY handshake) and returns read data and error status on a valid/ready response port. It is the initiator that drives the team's APB slave memory and register blocks, in both the test harness and the SoC fabric. It handles one transfer at a time, with a programmable wait-state timeout that aborts hung transfers.

## Interface
- AW, 32, address width
- DW, 32, data width; must be a multiple of 8
- SW, DW/8, strobe width
- TIMEOUT, 16, max PREADY-low ACCESS cycles before abort; 0 disables timeout
- PCLK  in  1  clock, all logic on rising edge
- PRESETn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at edge
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  AW  transfer address
- cmd_wdata  in  DW  write data
- cmd_strb  in  SW  write byte strobes
- cmd_prot  in  3  PPROT value
- cmd_nse  in  1  PNSE value
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready at edge
- rsp_rdata  out  DW  read data (0 for writes and timeouts)
- rsp_slverr  out  1  PSLVERR captured, or timeout
- rsp_timeout  out  1  transfer aborted by timeout
- PADDR  out  AW, PPROT out 3, PNSE out 1, PSEL out 1, PENABLE out 1, PWRITE out 1, PWDATA out DW, PSTRB out SW  APB requester outputs
- PRDATA  in  DW, PREADY in 1, PSLVERR in 1  APB completer inputs

## Operation
- States: IDLE, SETUP, ACCESS, RESP; one-hot or binary per implementer.
- IDLE: cmd_ready=1, PSEL=0, PENABLE=0. On cmd_valid: register the command onto PADDR/PWRITE/PPROT/PNSE. PWDATA=cmd_wdata and PSTRB=cmd_strb for writes; PWDATA=0 and PSTRB=0 for reads. Go to SETUP.
- SETUP: PSEL=1, PENABLE=0. PREADY is ignored. Always go to ACCESS next edge.
- ACCESS: PSEL=1, PENABLE=1. Wait counter cleared on entry.
  - Edge with PREADY=1: capture rsp_rdata=PRDATA (reads; 0 for writes) and rsp_slverr=PSLVERR, set rsp_timeout=0, go to RESP.
  - Edge with PREADY=0: increment counter. If TIMEOUT≠0 and the count reaches TIMEOUT, abort: rsp_rdata=0, rsp_slverr=1, rsp_timeout=1, go to RESP.
- RESP: PSEL=0, PENABLE=0, rsp_valid=1, response fields held. Go to IDLE on rsp_ready.
- cmd_ready is low in SETUP, ACCESS and RESP. Only one transfer is outstanding.
- PADDR, PWRITE, PPROT, PNSE, PWDATA and PSTRB are stable from SETUP through the end of ACCESS and hold their last value afterwards.
- Counter width: $clog2(TIMEOUT+1), saturating. It never wraps.

## Timing
- Reset (asynchronous, immediate): state=IDLE. PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT, PNSE = 0. rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout = 0. cmd_ready=1 while in IDLE, including during reset.
- Reset asserted mid-transfer drops PSEL/PENABLE asynchronously. The transfer is lost and no response is produced.
- Zero-wait completer with rsp_ready held high: accept at edge 0, SETUP in cycle 1, ACCESS in cycle 2 with PREADY sampled at edge 2, RESP in cycle 3, IDLE in cycle 4. Minimum 4 cycles per transfer.
- Each PREADY-low ACCESS cycle adds one cycle of latency.
- Timeout fires on the TIMEOUT-th consecutive PREADY-low ACCESS edge. PREADY=1 on that same edge wins: normal completion, no timeout.
- If rsp_ready=0, RESP holds indefinitely. No command is accepted until the response is consumed.
- cmd_valid changes outside IDLE are ignored. The command is captured only at the accept edge.

## Test plan
- Write 0x0000_0010, wdata 0xDEADBEEF, strb 0xF, PREADY=1 -> PSEL high 2 cycles, PENABLE high 1 cycle, PSTRB=0xF; rsp_valid in cycle 3 with slverr=0, rdata=0.
- Read 0x0000_0010 with PRDATA=0xDEADBEEF and 2 PREADY-low wait cycles -> ACCESS lasts 3 cycles, PSTRB=0, PWDATA=0; rsp_rdata=0xDEADBEEF.
- Write 0x0000_4000 with PSLVERR=1 at completion -> rsp_slverr=1, rsp_timeout=0.
- TIMEOUT=16 with PREADY held 0 -> abort after 16 ACCESS cycles, PSEL drops, rsp_slverr=1, rsp_timeout=1, rdata=0. Repeat with PREADY=1 on the 16th edge -> normal completion.
- Hold rsp_ready=0 for 5 cycles with cmd_valid=1 -> cmd_ready stays 0 and no second SETUP; after rsp_ready, the next command is accepted from IDLE.
- Assert PRESETn=0 in the middle of ACCESS -> PSEL/PENABLE go 0 immediately, all outputs return to reset values, and no rsp_valid is produced.
